// File: rtl/usb_fs_tx_buffer_if.sv
// -----------------------------------------------------------------------------
// usb_fs_tx_buffer_if
// Bundles the endpoint-writer side and the transmitter side of the
// single-packet USB full-speed transmit buffer.
//   slave  modport : the buffer itself
//   master modport : endpoint writer + transmitter (the buffer's neighbours)
// Endpoint side : wr_en, wr_data, wr_ready, level, send, send_pid, clear,
//                 busy, done, timeout_err
// Transmitter   : pkt_start, pid, tx_data_avail, tx_data_get, tx_data, pkt_end
// -----------------------------------------------------------------------------
interface usb_fs_tx_buffer_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    // endpoint writer
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic [AW:0]   level;
    logic          send;
    logic [3:0]    send_pid;
    logic          clear;
    logic          busy;
    logic          done;
    logic          timeout_err;

    // transmitter
    logic          pkt_start;
    logic [3:0]    pid;
    logic          tx_data_avail;
    logic          tx_data_get;
    logic [7:0]    tx_data;
    logic          pkt_end;

    modport slave (
        input  wr_en, wr_data, send, send_pid, clear, tx_data_get, pkt_end,
        output wr_ready, level, busy, done, timeout_err,
               pkt_start, pid, tx_data_avail, tx_data
    );

    modport master (
        output wr_en, wr_data, send, send_pid, clear, tx_data_get, pkt_end,
        input  wr_ready, level, busy, done, timeout_err,
               pkt_start, pid, tx_data_avail, tx_data
    );
endinterface

// File: rtl/usb_fs_tx_buffer.sv
// -----------------------------------------------------------------------------
// usb_fs_tx_buffer
// Single-packet transmit buffer in front of the USB full-speed transmitter.
// The endpoint loads up to DEPTH bytes (always from address 0), then issues
// send with a PID. The buffer pulses pkt_start, serves bytes show-ahead on
// tx_data_get and waits for pkt_end (or gives up after TIMEOUT_CYCLES).
// Payload is retained after a data packet so it can be retransmitted; the
// first write after a completed data packet starts a fresh payload.
// Ports:
//   clk   : system clock (transmitter domain)
//   reset : asynchronous, active-high reset
//   bus   : usb_fs_tx_buffer_if.slave (writer + transmitter handshakes)
// -----------------------------------------------------------------------------
module usb_fs_tx_buffer #(
    parameter int DEPTH          = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    usb_fs_tx_buffer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e          state_q, state_d;
    logic [AW:0]     len_q, len_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            sent_q, sent_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      pid_q, pid_d;
    logic            pkt_start_q, pkt_start_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;

    logic [7:0]      mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_addr;

    logic            wr_ready;
    logic            tx_avail;
    logic [AW:0]     len_eff;
    logic            sent_eff;

    // Full buffer still accepts a write once its payload has been sent,
    // because that write restarts the packet at address 0.
    assign wr_ready = (state_q == IDLE) && !bus.send && ((len_q < FULL) || sent_q);
    assign tx_avail = (state_q == SEND) && (pid_q[1:0] == 2'b11) && (rd_ptr_q < len_q);

    // clear takes effect before a same-cycle write or send
    assign len_eff  = bus.clear ? '0   : len_q;
    assign sent_eff = bus.clear ? 1'b0 : sent_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        len_d       = len_q;
        rd_ptr_d    = rd_ptr_q;
        sent_d      = sent_q;
        timer_d     = timer_q;
        pid_d       = pid_q;
        pkt_start_d = 1'b0;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;

        unique case (state_q)
            IDLE: begin
                len_d  = len_eff;
                sent_d = sent_eff;
                if (bus.send) begin
                    state_d     = SEND;
                    pid_d       = bus.send_pid;
                    pkt_start_d = 1'b1;
                    rd_ptr_d    = '0;
                    timer_d     = '0;
                end else if (bus.wr_en && wr_ready) begin
                    mem_we = 1'b1;
                    if (sent_eff) begin
                        mem_addr = '0;
                        len_d    = (AW + 1)'(1);
                        sent_d   = 1'b0;
                    end else begin
                        mem_addr = len_eff[AW-1:0];
                        len_d    = len_eff + 1'b1;
                    end
                end
            end

            SEND: begin
                timer_d = timer_q + 1'b1;
                if (bus.tx_data_get && tx_avail)
                    rd_ptr_d = rd_ptr_q + 1'b1;
                // pkt_end has priority over an expiring timer
                if (bus.pkt_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (pid_q[1:0] == 2'b11)
                        sent_d = 1'b1;
                end else if (timer_q == T_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= IDLE;
            len_q       <= '0;
            rd_ptr_q    <= '0;
            sent_q      <= 1'b0;
            timer_q     <= '0;
            pid_q       <= '0;
            pkt_start_q <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_ptr_q    <= rd_ptr_d;
            sent_q      <= sent_d;
            timer_q     <= timer_d;
            pid_q       <= pid_d;
            pkt_start_q <= pkt_start_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    // NOTE: payload storage has no reset; len_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_addr] <= bus.wr_data;
    end

    assign bus.wr_ready      = wr_ready;
    assign bus.level         = len_q;
    assign bus.busy          = (state_q == SEND);
    assign bus.done          = done_q;
    assign bus.timeout_err   = timeout_q;
    assign bus.pkt_start     = pkt_start_q;
    assign bus.pid           = pid_q;
    assign bus.tx_data_avail = tx_avail;
    // show-ahead: rd_ptr only moves on a get, so the byte holds until consumed
    assign bus.tx_data       = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_usb_fs_tx_buffer.sv
// -----------------------------------------------------------------------------
// tb_usb_fs_tx_buffer
// Directed bench for usb_fs_tx_buffer with DEPTH=8, TIMEOUT_CYCLES=16.
// -----------------------------------------------------------------------------
module tb_usb_fs_tx_buffer;
    localparam int DEPTH = 8;
    localparam int TOC   = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] exp_bytes [8];

    usb_fs_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

    usb_fs_tx_buffer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TOC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // issue send, then check the first SEND cycle
    task automatic do_send(input logic [3:0] p, input string tag);
        bus.send     = 1'b1;
        bus.send_pid = p;
        #1;
        chk({tag, "_wr_ready_during_send"}, 32'(bus.wr_ready), 0);
        tick();
        bus.send = 1'b0;
        chk({tag, "_pkt_start"}, 32'(bus.pkt_start), 1);
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        chk({tag, "_pid"}, 32'(bus.pid), 32'(p));
        tick();
        chk({tag, "_pkt_start_once"}, 32'(bus.pkt_start), 0);
    endtask

    // consume n bytes, comparing against exp_bytes, then expect no more data
    task automatic serve(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_avail%0d", tag, i), 32'(bus.tx_data_avail), 1);
            chk($sformatf("%s_data%0d", tag, i), 32'(bus.tx_data), 32'(exp_bytes[i]));
            bus.tx_data_get = 1'b1;
            tick();
            bus.tx_data_get = 1'b0;
        end
        chk({tag, "_avail_end"}, 32'(bus.tx_data_avail), 0);
    endtask

    task automatic finish_pkt(input string tag);
        bus.pkt_end = 1'b1;
        tick();
        bus.pkt_end = 1'b0;
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_busy_low"}, 32'(bus.busy), 0);
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done), 0);
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_data = 0; bus.send = 0; bus.send_pid = 0;
        bus.clear = 0; bus.tx_data_get = 0; bus.pkt_end = 0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_pkt_start", 32'(bus.pkt_start), 0);
        chk("rst_pid", 32'(bus.pid), 0);
        chk("rst_avail", 32'(bus.tx_data_avail), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_timeout", 32'(bus.timeout_err), 0);
        reset = 1'b0;
        tick();
        chk("rst_wr_ready", 32'(bus.wr_ready), 1);

        // 1: three bytes, DATA0
        wr(8'h11); wr(8'h22); wr(8'h33);
        chk("t1_level", 32'(bus.level), 3);
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
        do_send(4'h3, "t1");
        serve(3, "t1");
        finish_pkt("t1");

        // 2: retransmit identical payload
        do_send(4'h3, "t2");
        serve(3, "t2");
        finish_pkt("t2");
        chk("t2_level", 32'(bus.level), 3);

        // 3: write after sent restarts the payload
        wr(8'hAA);
        chk("t3_level", 32'(bus.level), 1);
        exp_bytes[0] = 8'hAA;
        do_send(4'h3, "t3");
        serve(1, "t3");
        finish_pkt("t3");

        // 4: ACK with 5 bytes: no data served, contents kept, sent unchanged
        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04); wr(8'h05);
        chk("t4_level", 32'(bus.level), 5);
        do_send(4'h2, "t4");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_avail%0d", i), 32'(bus.tx_data_avail), 0);
            bus.tx_data_get = 1'b1;
            tick();
            bus.tx_data_get = 1'b0;
        end
        finish_pkt("t4");
        chk("t4_level_kept", 32'(bus.level), 5);
        wr(8'h06);
        chk("t4_append", 32'(bus.level), 6);

        // 5: fill to DEPTH, dropped write, clear+send
        wr(8'h07); wr(8'h08);
        chk("t5_level_full", 32'(bus.level), DEPTH);
        chk("t5_wr_ready", 32'(bus.wr_ready), 0);
        wr(8'hFF);
        chk("t5_drop", 32'(bus.level), DEPTH);
        bus.clear = 1'b1;
        bus.send = 1'b1;
        bus.send_pid = 4'hB;
        tick();
        bus.clear = 1'b0;
        bus.send = 1'b0;
        chk("t5_pkt_start", 32'(bus.pkt_start), 1);
        chk("t5_level_zero", 32'(bus.level), 0);
        chk("t5_pid", 32'(bus.pid), 32'hB);
        chk("t5_avail", 32'(bus.tx_data_avail), 0);
        finish_pkt("t5");

        // 6: timeout 16 cycles after pkt_start
        bus.send = 1'b1;
        bus.send_pid = 4'h3;
        tick();
        bus.send = 1'b0;
        chk("t6_pkt_start", 32'(bus.pkt_start), 1);
        for (int i = 1; i < TOC; i++) begin
            tick();
            chk($sformatf("t6_wait%0d", i), {bus.timeout_err, bus.busy}, 2'b01);
        end
        tick();
        chk("t6_timeout", 32'(bus.timeout_err), 1);
        chk("t6_idle", 32'(bus.busy), 0);
        chk("t6_no_done", 32'(bus.done), 0);
        tick();
        chk("t6_timeout_pulse", 32'(bus.timeout_err), 0);

        // 6b: pkt_end on the expiring cycle wins
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        for (int i = 1; i < TOC; i++) tick();
        chk("t6b_still_busy", 32'(bus.busy), 1);
        bus.pkt_end = 1'b1;
        tick();
        bus.pkt_end = 1'b0;
        chk("t6b_done", 32'(bus.done), 1);
        chk("t6b_no_timeout", 32'(bus.timeout_err), 0);
        tick();

        // 7: reset mid-SEND
        wr(8'h55);
        chk("t7_level", 32'(bus.level), 1);
        bus.send = 1'b1;
        bus.send_pid = 4'h7;
        tick();
        bus.send = 1'b0;
        chk("t7_avail", 32'(bus.tx_data_avail), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_busy", 32'(bus.busy), 0);
        chk("t7_pkt_start", 32'(bus.pkt_start), 0);
        chk("t7_pid", 32'(bus.pid), 0);
        chk("t7_avail_rst", 32'(bus.tx_data_avail), 0);
        chk("t7_level_rst", 32'(bus.level), 0);
        chk("t7_done", 32'(bus.done), 0);
        chk("t7_timeout", 32'(bus.timeout_err), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t7_wr_ready", 32'(bus.wr_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/usb_fs_tx_buffer.md
Name: usb_fs_tx_buffer

Overview:
- Single-packet transmit buffer that sits directly upstream of the full-speed USB transmitter and feeds its packet-start / PID / byte-pull interface.
- An endpoint writer loads up to DEPTH payload bytes, then requests a send with a PID. The block starts the transmitter, serves bytes on demand and waits for end-of-packet.
- Contents are retained after a send, so the same payload can be retransmitted on NAK or timeout.

Parameters:
- DEPTH, 64, payload capacity in bytes; power of two, 8..1024. AW = log2(DEPTH) is derived internally.
- TIMEOUT_CYCLES, 4096, clk cycles allowed in SEND before the packet is abandoned; must be >= 2.

Ports:
- clk  in  1  system clock (transmitter's clk domain).
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for wr_data; accepted only when wr_ready=1.
- wr_data  in  8  payload byte.
- wr_ready  out  1  buffer can accept a byte this cycle.
- level  out  AW+1  current payload length in bytes, 0..DEPTH.
- send  in  1  request transmission of current contents with send_pid.
- send_pid  in  4  PID latched on an accepted send.
- clear  in  1  empty the buffer (IDLE only).
- busy  out  1  packet in flight (state != IDLE).
- done  out  1  one-cycle pulse on pkt_end.
- timeout_err  out  1  one-cycle pulse when TIMEOUT_CYCLES expires.
- pkt_start  out  1  one-cycle pulse to the transmitter.
- pid  out  4  PID to the transmitter; stable from pkt_start until return to IDLE.
- tx_data_avail  out  1  a payload byte is available.
- tx_data_get  in  1  one-cycle strobe: transmitter has consumed tx_data.
- tx_data  out  8  current byte (show-ahead).
- pkt_end  in  1  one-cycle strobe from the transmitter: EOP complete.

Behaviour:
- Reset values: pkt_start=0, pid=0, tx_data_avail=0, busy=0, done=0, timeout_err=0, level=0, rd_ptr=0, sent flag=0, state=IDLE. wr_ready=1 in the first cycle after reset. Reset mid-packet aborts immediately; the transmitter is not signalled.
- Storage:
  - DEPTH x 8 array; each packet always starts at address 0. Not circular.
  - len register (=level) holds the payload length. rd_ptr (AW+1 bits) holds the next byte to serve.
- States: IDLE, SEND.
- Writes:
  - wr_ready = IDLE && !send && (len < DEPTH || sent).
  - Accepted wr_en with sent=1: store at address 0, len<=1, sent<=0. This starts a new packet.
  - Accepted wr_en with sent=0: store at address len, len<=len+1.
  - wr_en with wr_ready=0 is dropped silently; no state change.
- clear:
  - In IDLE: len<=0, sent<=0.
  - In SEND: ignored.
  - clear and send in the same IDLE cycle: clear is applied, then the send is accepted as a zero-length packet.
- send (IDLE only; ignored in SEND):
  - Next cycle: pid<=send_pid, pkt_start=1 for exactly one cycle, rd_ptr<=0, timer<=0, state<=SEND, busy=1.
  - send and wr_en in the same cycle: the send wins and the write is dropped (wr_ready=0 that cycle).
- SEND:
  - tx_data_avail = (pid[1:0]==2'b11) && (rd_ptr < len). Combinational from registers.
  - tx_data = mem[rd_ptr], valid whenever tx_data_avail=1. It must stay stable until tx_data_get, because the transmitter samples before strobing.
  - tx_data_get with tx_data_avail=1: rd_ptr<=rd_ptr+1.
  - tx_data_get with tx_data_avail=0: ignored.
  - Non-data PID (pid[1:0]!=11): tx_data_avail stays 0 and buffer contents are untouched.
  - Zero-length data packet: tx_data_avail=0 from the start; the transmitter sends CRC only.
- Completion:
  - pkt_end in SEND: next cycle state<=IDLE, done=1 for one cycle.
  - If pid was a data PID: sent<=1. len and contents are kept, so a later send retransmits the identical payload.
  - pkt_end in IDLE: ignored.
- Timeout:
  - Timer increments every SEND cycle. On reaching TIMEOUT_CYCLES-1 without pkt_end: state<=IDLE, timeout_err=1 for one cycle, sent unchanged.
  - pkt_end and timeout in the same cycle: pkt_end wins (done=1, timeout_err=0).
- len saturates at DEPTH; rd_ptr never exceeds len.

Test Plan:
- Load 3 bytes 0x11,0x22,0x33, then send with PID 0x3 (DATA0).
  - Required: level=3; pkt_start pulses once; pid=0x3; tx_data shows 0x11, 0x22, 0x33 on successive gets; tx_data_avail drops after the third get.
  - pkt_end then gives done=1 and busy=0.
- Same buffer after done, send again with PID 0x3 → identical 3-byte sequence served (retransmit); level stays 3.
- After done, one write of 0xAA → level=1. Next send serves only 0xAA.
- Send with PID 0x2 (ACK) and buffer holding 5 bytes → tx_data_avail stays 0 throughout. After pkt_end, level=5 and sent is unchanged, so the next write appends (level=6).
- Write DEPTH bytes → wr_ready=0. An extra wr_en is dropped and level=DEPTH. clear+send in the same cycle → zero-length packet with tx_data_avail=0.
- TIMEOUT_CYCLES=16, send, withhold pkt_end → timeout_err pulses 16 cycles after pkt_start; state returns to IDLE. Assert reset mid-SEND → all outputs return to their reset values immediately.
